// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage.
//  - Bus widths for EX->MEM, MEM->WB and MEM->ID.
//  - Stall bus layout and the Stop/NoStop encodings.
//  - Bit positions of the one-hot load opcode.
//  - Packed view of the EX->MEM bus.
//  - The two states of the read-data hold buffer.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 81;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_WD     = 6;

  // Stall bus bit positions and encodings
  localparam int   STALL_EX  = 3;
  localparam int   STALL_MEM = 4;
  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;

  // One-hot load opcode bits: {lb, lbu, lh, lhu, lw}
  localparam int LD_LB  = 4;
  localparam int LD_LBU = 3;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 1;
  localparam int LD_LW  = 0;

  typedef struct packed {
    logic [4:0]  ld_op;         // 80:76
    logic [31:0] pc;            // 75:44
    logic        data_ram_en;   // 43
    logic [3:0]  data_ram_wen;  // 42:39
    logic        sel_rf_res;    // 38
    logic        rf_we;         // 37
    logic [4:0]  rf_waddr;      // 36:32
    logic [31:0] ex_result;     // 31:0
  } ex_to_mem_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extraction and extension (purely combinational).
//
// Ports:
//  rsel   in   32  SRAM read word (live or held)
//  addr   in    2  low address bits (byte offset)
//  ld_op  in    5  one-hot {lb, lbu, lh, lhu, lw}
//  data   out  32  extracted and sign/zero-extended load value
//
// For halfword loads addr[0] is ignored; misalignment is trapped upstream.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rsel,
  input  logic [1:0]  addr,
  input  logic [4:0]  ld_op,
  output logic [31:0] data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the word into its four byte lanes
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rsel[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lanes[addr];
  assign half_sel = addr[1] ? rsel[31:16] : rsel[15:0];

  always_comb begin
    data = rsel;
    if (ld_op[LD_LB]) begin
      data = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_op[LD_LBU]) begin
      data = {24'b0, byte_sel};
    end else if (ld_op[LD_LH]) begin
      data = {{16{half_sel[15]}}, half_sel};
    end else if (ld_op[LD_LHU]) begin
      data = {16'b0, half_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between EX and WB.
//
// Registers the EX->MEM bus. The data SRAM returns its read word in the
// cycle after EX issued the request, which is the cycle the instruction
// sits in this stage. The stage then extracts and extends the load data.
// It drives the MEM->WB bus and the MEM->ID forwarding bus from that data.
//
// A one-entry hold buffer captures the read word on the first stalled
// cycle. A load stalled in MEM therefore keeps its value even if the SRAM
// output changes later.
//
// Ports:
//  clk              in   1   clock
//  rst              in   1   asynchronous, active-high reset
//  flush            in   1   turn the MEM register into a bubble
//  stall            in   6   stall bus (bit3 = EX, bit4 = MEM)
//  ex_to_mem_bus    in  81   {ld_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//  data_sram_rdata  in  32   SRAM read word
//  mem_to_wb_bus    out 70   {mem_pc, rf_we, rf_waddr, rf_wdata}
//  mem_to_id_bus    out 38   {rf_we, rf_waddr, rf_wdata} forwarding copy
//  mem_is_load      out  1   instruction in MEM is a load
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit HOLD_RDATA = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    mem_is_load
);

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
  ex_to_mem_t              bus_f;
  logic                    is_load;
  logic                    hold_valid;
  logic [31:0]             rdata_hold;
  logic [31:0]             rsel;
  logic [31:0]             load_data;
  logic [31:0]             rf_wdata;

  // Only the EX and MEM stall bits matter here
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // EX->MEM pipeline register. EX stalled while MEM runs means the
  // instruction in MEM moves on and nothing replaces it, so insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_to_mem_bus_r <= '0;
    end else if (flush) begin
      ex_to_mem_bus_r <= '0;
    end else if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) begin
      ex_to_mem_bus_r <= '0;
    end else if (stall[STALL_EX] == NO_STOP) begin
      ex_to_mem_bus_r <= ex_to_mem_bus;
    end
  end

  assign bus_f   = ex_to_mem_bus_r;
  assign is_load = bus_f.data_ram_en && (bus_f.data_ram_wen == 4'b0) && (bus_f.ld_op != 5'b0);

  // Read-data hold buffer
  generate
    if (HOLD_RDATA) begin : g_hold
      hold_state_t state_reg;
      hold_state_t state_next;
      logic [31:0] rdata_hold_reg;

      always_comb begin
        state_next = state_reg;
        if (flush) begin
          state_next = HOLD_EMPTY;
        end else begin
          case (state_reg)
            HOLD_EMPTY: if (stall[STALL_MEM] == STOP && is_load) state_next = HOLD_HELD;
            HOLD_HELD:  if (stall[STALL_MEM] == NO_STOP)         state_next = HOLD_EMPTY;
            default:    state_next = HOLD_EMPTY;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg      <= HOLD_EMPTY;
          rdata_hold_reg <= '0;
        end else begin
          state_reg <= state_next;
          // Capture only on entry. The word is valid solely in the first MEM cycle.
          if (state_reg == HOLD_EMPTY && state_next == HOLD_HELD) begin
            rdata_hold_reg <= data_sram_rdata;
          end
        end
      end

      assign hold_valid = (state_reg == HOLD_HELD);
      assign rdata_hold = rdata_hold_reg;
    end else begin : g_no_hold
      assign hold_valid = 1'b0;
      assign rdata_hold = '0;
    end
  endgenerate

  assign rsel = hold_valid ? rdata_hold : data_sram_rdata;

  load_ext u_load_ext (
    .rsel  (rsel),
    .addr  (bus_f.ex_result[1:0]),
    .ld_op (bus_f.ld_op),
    .data  (load_data)
  );

  assign rf_wdata      = (bus_f.sel_rf_res && is_load) ? load_data : bus_f.ex_result;
  assign mem_to_wb_bus = {bus_f.pc, bus_f.rf_we, bus_f.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {bus_f.rf_we, bus_f.rf_waddr, rf_wdata};
  assign mem_is_load   = is_load;

endmodule
